// File: rtl/riscv_fpu_types_pkg.sv
`default_nettype none
// ============================================================================
// riscv_fpu_types_pkg: FPU request/response types and arbiter definitions.
// Rev 1.0
// ============================================================================
package riscv_fpu_types_pkg;

  typedef enum logic [3:0] {
    FPU_ADD  = 4'd0,
    FPU_SUB  = 4'd1,
    FPU_MUL  = 4'd2,
    FPU_DIV  = 4'd3,
    FPU_SQRT = 4'd4,
    FPU_FMA  = 4'd5,
    FPU_CVT  = 4'd6,
    FPU_CMP  = 4'd7
  } fpu_op_e;

  typedef struct packed {
    logic        valid;
    fpu_op_e     op;
    logic [2:0]  rm;
    logic [4:0]  rd_addr;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
  } fpu_req_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd_addr;
    logic [31:0] data;
    logic [4:0]  fflags;
  } fpu_rsp_t;

  typedef enum logic [0:0] {
    ARB_RUN   = 1'b0,
    ARB_DRAIN = 1'b1
  } fpu_arb_state_e;

  localparam int FPU_ARB_MAX_REQ = 8;

  typedef logic [2:0] fpu_tag_t;

  // Round-robin successor of a requester index among n requesters.
  function automatic fpu_tag_t fpu_arb_next_tag(input fpu_tag_t t, input int n);
    return (int'(t) >= n - 1) ? '0 : fpu_tag_t'(t + 3'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_fpu_tag_fifo.sv
`default_nettype none
// ============================================================================
// riscv_fpu_tag_fifo: synchronous FIFO; a push is accepted when full if a pop
// happens in the same cycle. Rev 1.0
// ============================================================================
module riscv_fpu_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    full_o   = (count_q == CNT_W'(DEPTH));
    empty_o  = (count_q == '0);
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & (~full_o | do_pop);
    // DEPTH is a power of two, so pointers wrap by natural overflow.
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    data_o   = mem_q[rd_ptr_q];
    count_o  = count_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/riscv_fpu_arbiter.sv
`default_nettype none
// ============================================================================
// riscv_fpu_arbiter: round-robin sharing of one in-order pipelined FPU with
// tag-FIFO response routing and flush/drain control.
// Optional macro RISCV_FPU_ARB_PERF_EN adds grant/stall counters. Rev 1.0
// ============================================================================
module riscv_fpu_arbiter
  import riscv_fpu_types_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  fpu_req_t           req_i [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ready_o,
  output fpu_rsp_t           rsp_o [NUM_REQ],
  output fpu_req_t           fpu_req_o,
  input  logic               fpu_ready_i,
  input  fpu_rsp_t           fpu_rsp_i,
  input  logic               flush_i,
  output logic               flush_done_o,
  output logic               spurious_rsp_o
`ifdef RISCV_FPU_ARB_PERF_EN
  ,
  output logic [31:0]        perf_grant_cnt_o [NUM_REQ],
  output logic [31:0]        perf_stall_cnt_o
`endif
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);

  fpu_arb_state_e   state_q, state_d;
  fpu_tag_t         ptr_q, ptr_d;
  logic             flush_done_q, flush_done_d;
  logic             spurious_q, spurious_d;

  logic             grant_vld, issue, pop, eligible;
  fpu_tag_t         winner, head_tag;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count, count_next;

  riscv_fpu_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH ($bits(fpu_tag_t))
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (issue),
    .data_i  (winner),
    .pop_i   (pop),
    .data_o  (head_tag),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Arbitration and issue; rst_i keeps every grant low while reset is held.
  always_comb begin
    pop         = fpu_rsp_i.valid & ~fifo_empty;
    eligible    = ~rst_i && (state_q == ARB_RUN) && ~flush_i && (~fifo_full || pop);
    grant_vld   = 1'b0;
    winner      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (eligible && !grant_vld && req_i[k].valid &&
            (((int'(ptr_q) + i) % NUM_REQ) == k)) begin
          grant_vld = 1'b1;
          winner    = fpu_tag_t'(k);
        end
      end
    end
    fpu_req_o   = '0;
    req_ready_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_vld && (winner == fpu_tag_t'(k))) begin
        fpu_req_o       = req_i[k];
        fpu_req_o.valid = 1'b1;
        req_ready_o[k]  = fpu_ready_i;
      end
    end
    issue      = grant_vld & fpu_ready_i;
    ptr_d      = issue ? fpu_arb_next_tag(winner, NUM_REQ) : ptr_q;
    count_next = fifo_count + CNT_W'(issue) - CNT_W'(pop);
    spurious_d = spurious_q | (fpu_rsp_i.valid & fifo_empty);
  end

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      rsp_o[k]       = fpu_rsp_i;
      rsp_o[k].valid = pop && (head_tag == fpu_tag_t'(k));
    end
  end

  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      ARB_RUN: begin
        if (flush_i) state_d = ARB_DRAIN;
      end
      ARB_DRAIN: begin
        flush_done_d = (count_next == '0) && flush_i;
        // Leaving DRAIN waits for every outstanding op even if flush_i drops.
        if (!flush_i && (fifo_count == '0)) state_d = ARB_RUN;
      end
      default: state_d = ARB_RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ARB_RUN;
      ptr_q        <= '0;
      flush_done_q <= 1'b0;
      spurious_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      flush_done_q <= flush_done_d;
      spurious_q   <= spurious_d;
    end
  end

  assign flush_done_o   = flush_done_q;
  assign spurious_rsp_o = spurious_q;

`ifdef RISCV_FPU_ARB_PERF_EN
  logic [31:0] perf_grant_q [NUM_REQ];
  logic [31:0] perf_grant_d [NUM_REQ];
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        any_vld;

  always_comb begin
    any_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      any_vld = any_vld | req_i[k].valid;
    end
    perf_stall_d = (any_vld && !issue && (perf_stall_q != '1)) ? perf_stall_q + 32'd1
                                                             : perf_stall_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      perf_grant_d[k] = (issue && (winner == fpu_tag_t'(k)) && (perf_grant_q[k] != '1))
                        ? perf_grant_q[k] + 32'd1 : perf_grant_q[k];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_stall_q <= '0;
      for (int k = 0; k < NUM_REQ; k++) perf_grant_q[k] <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      for (int k = 0; k < NUM_REQ; k++) perf_grant_q[k] <= perf_grant_d[k];
    end
  end

  assign perf_grant_cnt_o = perf_grant_q;
  assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_fpu_arbiter.sv
`default_nettype none
// ============================================================================
// tb_riscv_fpu_arbiter: directed vector table plus hand sequences for the
// multi-cycle cases of the FPU arbiter (NUM_REQ=2, MAX_OUTSTANDING=4). Rev 1.0
// ============================================================================
module tb_riscv_fpu_arbiter;
  import riscv_fpu_types_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  fpu_req_t   req [2];
  logic [1:0] req_ready;
  fpu_rsp_t   rsp [2];
  fpu_req_t   fpu_req;
  logic       fpu_ready;
  fpu_rsp_t   fpu_rsp;
  logic       flush;
  logic       flush_done;
  logic       spurious;

  int n_chk  = 0;
  int n_fail = 0;

  riscv_fpu_arbiter #(
    .NUM_REQ         (2),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_i          (req),
    .req_ready_o    (req_ready),
    .rsp_o          (rsp),
    .fpu_req_o      (fpu_req),
    .fpu_ready_i    (fpu_ready),
    .fpu_rsp_i      (fpu_rsp),
    .flush_i        (flush),
    .flush_done_o   (flush_done),
    .spurious_rsp_o (spurious)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v0, v1, rdy, rspv;
    logic [31:0] data;
    logic [1:0]  exp_rdy;
    logic        exp_fvld;
    logic [4:0]  exp_rd;
    logic [1:0]  exp_rspv;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic v1, input logic rdy,
                       input logic rspv, input logic [31:0] data);
    req[0].valid  = v0;
    req[1].valid  = v1;
    fpu_ready     = rdy;
    fpu_rsp.valid = rspv;
    fpu_rsp.data  = data;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rspv_vec();
    return {30'd0, rsp[1].valid, rsp[0].valid};
  endfunction

  initial begin
    // Table assumes pointer 0 and an empty FIFO at entry.
    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         2'b10, 1'b1, 5'd11, 2'b00};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         2'b01, 1'b1, 5'd10, 2'b00};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         2'b10, 1'b1, 5'd11, 2'b00};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h1111_0001, 2'b00, 1'b1, 5'd10, 2'b10};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h1111_0002, 2'b00, 1'b1, 5'd11, 2'b01};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h1111_0003, 2'b00, 1'b0, 5'd0,  2'b10};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         2'b00, 1'b0, 5'd0,  2'b00};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         2'b01, 1'b1, 5'd10, 2'b00};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h1111_0004, 2'b10, 1'b1, 5'd11, 2'b01};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h1111_0005, 2'b00, 1'b0, 5'd0,  2'b10};

    req[0] = '0; req[0].op = FPU_MUL; req[0].rd_addr = 5'd10;
    req[1] = '0; req[1].op = FPU_ADD; req[1].rd_addr = 5'd11;
    fpu_rsp = '0;
    flush   = 1'b0;
    rst     = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

    // Reset state: no grants even with requests present.
    @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'h0);
    chk("reset_fvld", 32'(fpu_req.valid), 32'h0);
    chk("reset_flush_done", 32'(flush_done), 32'h0);
    chk("reset_spurious", 32'(spurious), 32'h0);
    chk("reset_rspv", rspv_vec(), 32'h0);
    next_cycle();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].v0, vecs[i].v1, vecs[i].rdy, vecs[i].rspv, vecs[i].data);
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].exp_rdy));
      chk($sformatf("vec%0d_fvld", i), 32'(fpu_req.valid), 32'(vecs[i].exp_fvld));
      if (vecs[i].exp_fvld) chk($sformatf("vec%0d_rd", i), 32'(fpu_req.rd_addr), 32'(vecs[i].exp_rd));
      chk($sformatf("vec%0d_rspv", i), rspv_vec(), 32'(vecs[i].exp_rspv));
      for (int k = 0; k < 2; k++) begin
        if (vecs[i].exp_rspv[k]) chk($sformatf("vec%0d_data%0d", i, k), rsp[k].data, vecs[i].data);
      end
      next_cycle();
    end
    chk("table_spurious", 32'(spurious), 32'h0);

    // Single issue, response three cycles later.
    req[1].rd_addr = 5'd5;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("single_rd", 32'(fpu_req.rd_addr), 32'd5);
    chk("single_op", 32'(fpu_req.op), 32'(FPU_ADD));
    chk("single_ready", 32'(req_ready), 32'h2);
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    next_cycle();
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h4040_0000);
    @(negedge clk);
    chk("single_rspv", rspv_vec(), 32'h2);
    chk("single_data", rsp[1].data, 32'h4040_0000);
    next_cycle();
    req[1].rd_addr = 5'd11;

    // Round-robin with 2-cycle FPU latency.
    for (int c = 0; c < 8; c++) begin
      drive(c < 6, c < 6, 1'b1, c >= 2, 32'h2000_0000 + 32'(c));
      @(negedge clk);
      if (c < 6) chk($sformatf("rr%0d_ready", c), 32'(req_ready), (c % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("rr%0d_rspv", c), rspv_vec(),
          (c >= 2) ? ((c % 2 == 0) ? 32'h1 : 32'h2) : 32'h0);
      next_cycle();
    end

    // Full FIFO: four issues, then stall, then push+pop at full.
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      chk($sformatf("fill%0d_ready", c), 32'(req_ready), (c % 2 == 0) ? 32'h1 : 32'h2);
      next_cycle();
    end
    @(negedge clk);
    chk("full_ready", 32'(req_ready), 32'h0);
    chk("full_fvld", 32'(fpu_req.valid), 32'h0);
    next_cycle();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hAAAA_0000);
    @(negedge clk);
    chk("fullpp_rspv", rspv_vec(), 32'h1);
    chk("fullpp_ready", 32'(req_ready), 32'h1);
    next_cycle();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("still_full_ready", 32'(req_ready), 32'h0);
    next_cycle();
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hBBBB_0000 + 32'(c));
      @(negedge clk);
      chk($sformatf("drain%0d_rspv", c), rspv_vec(), (c % 2 == 0) ? 32'h2 : 32'h1);
      next_cycle();
    end

    // Backpressure: pointer is 1; requester 0 alone waits on the FPU.
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk($sformatf("bp%0d_ready", c), 32'(req_ready), 32'h0);
      chk($sformatf("bp%0d_fvld", c), 32'(fpu_req.valid), 32'h1);
      next_cycle();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("bp_ptr_held_rd", 32'(fpu_req.rd_addr), 32'd11);
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("bp_release_ready", 32'(req_ready), 32'h1);
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hCCCC_0000);
    @(negedge clk);
    chk("bp_rspv", rspv_vec(), 32'h1);
    next_cycle();

    // Flush with two ops outstanding.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("fl_issue0", 32'(req_ready), 32'h2);
    next_cycle();
    @(negedge clk);
    chk("fl_issue1", 32'(req_ready), 32'h1);
    next_cycle();
    flush = 1'b1;
    @(negedge clk);
    chk("fl_f0_fvld", 32'(fpu_req.valid), 32'h0);
    next_cycle();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hDDDD_0001);
    @(negedge clk);
    chk("fl_f1_fvld", 32'(fpu_req.valid), 32'h0);
    chk("fl_f1_rspv", rspv_vec(), 32'h2);
    chk("fl_f1_done", 32'(flush_done), 32'h0);
    next_cycle();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hDDDD_0002);
    @(negedge clk);
    chk("fl_f2_rspv", rspv_vec(), 32'h1);
    chk("fl_f2_done", 32'(flush_done), 32'h0);
    next_cycle();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("fl_f3_done", 32'(flush_done), 32'h1);
    chk("fl_f3_fvld", 32'(fpu_req.valid), 32'h0);
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    chk("fl_f4_fvld", 32'(fpu_req.valid), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("fl_f5_done", 32'(flush_done), 32'h0);
    chk("fl_f5_ready", 32'(req_ready), 32'h2);
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hDDDD_0003);
    @(negedge clk);
    chk("fl_f6_rspv", rspv_vec(), 32'h2);
    next_cycle();

    // Reset with three ops in flight, then a late FPU response.
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      chk($sformatf("sp_issue%0d", c), 32'(req_ready), 32'h1);
      next_cycle();
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("sp_rst_ready", 32'(req_ready), 32'h0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("sp_pre_spurious", 32'(spurious), 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hEEEE_0000);
    @(negedge clk);
    chk("sp_rspv", rspv_vec(), 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("sp_spurious", 32'(spurious), 32'h1);
    next_cycle();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("sp_ptr_reset_ready", 32'(req_ready), 32'h1);
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hEEEE_0001);
    @(negedge clk);
    chk("sp_post_rspv", rspv_vec(), 32'h1);
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("sp_sticky", 32'(spurious), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/riscv_fpu_arbiter.md
Name: riscv_fpu_arbiter

Overview:
- Shares one pipelined FPU between NUM_REQ requesters, such as per-hart issue slots or the core pipeline plus a vector/debug requester.
- Performs round-robin arbitration on fpu_req_t requests.
- Records the winner's index in an in-order tag FIFO, then routes each fpu_rsp_t back to the requester that issued it.
- Provides a flush/drain controller so the pipeline can quiesce the FPU before a context switch or exception.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- MAX_OUTSTANDING, 4: tag FIFO depth, i.e. the maximum number of ops in flight inside the FPU (power of two, ≥2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_i  in  NUM_REQ x fpu_req_t  per-requester request; .valid marks a request.
- req_ready_o  out  NUM_REQ  accept strobe; the request transfers when req_i[k].valid & req_ready_o[k].
- rsp_o  out  NUM_REQ x fpu_rsp_t  routed response, with .valid as a one-cycle pulse.
- fpu_req_o  out  fpu_req_t  request to the FPU.
- fpu_ready_i  in  1  FPU can accept a request this cycle.
- fpu_rsp_i  in  fpu_rsp_t  FPU response; responses return in issue order.
- flush_i  in  1  level; stop issuing and drain.
- flush_done_o  out  1  FPU idle with no outstanding ops while flushing.
- spurious_rsp_o  out  1  sticky: a response arrived with the FIFO empty.

Behaviour:
- **Reset** (async, rst_i high):
  - tag FIFO empty, count = 0;
  - RR pointer = 0;
  - FSM = RUN;
  - flush_done_o = 0, spurious_rsp_o = 0.
  - All rsp_o[k].valid = 0, req_ready_o = 0, fpu_req_o.valid = 0.
  - Reset mid-operation discards all tags. FPU responses arriving afterwards are dropped and set spurious_rsp_o.
- **Arbitration** (combinational within the cycle):
  - Eligible when state == RUN and the FIFO can accept: count < MAX_OUTSTANDING, or a pop happens in the same cycle.
  - Winner = first valid requester scanning pointer, pointer+1, ... wrapping modulo NUM_REQ.
  - fpu_req_o = req_i[winner] with .valid = 1. With no eligible winner, fpu_req_o.valid = 0 and the other fields are don't-care.
  - req_ready_o[winner] = fpu_ready_i; all other ready bits are 0.
- **Issue handshake** (fpu_req_o.valid & fpu_ready_i):
  - push winner index into the tag FIFO;
  - pointer <= (winner + 1) mod NUM_REQ.
  - With no issue, the pointer holds.
  - Requesters hold their request stable until accepted.
  - Issue latency is 0 cycles: a request presented in cycle t with the FPU ready is issued in cycle t.
- **Response** (fpu_rsp_i.valid):
  - If count > 0: pop the head tag h; in the same cycle rsp_o[h] = fpu_rsp_i with valid = 1 (combinational routing). All other rsp_o[k].valid = 0.
  - If count == 0: drop the response and set spurious_rsp_o <= 1. It stays set until reset.
- **Simultaneous push and pop**: count unchanged. This is allowed when full, so the FIFO sustains 1 op/cycle at MAX_OUTSTANDING.
- **Count width**: $clog2(MAX_OUTSTANDING+1). Read/write pointers wrap at MAX_OUTSTANDING.
- **FSM states**:
  - RUN: arbitrate normally. Go to DRAIN when flush_i = 1; no grant is made in that same cycle.
  - DRAIN: no grants; responses still route.
    - flush_done_o <= (count_next == 0) & flush_i, registered.
    - Go to RUN when flush_i = 0 and count == 0.
    - If flush_i drops with ops outstanding, stay in DRAIN until count == 0.
  - flush_done_o is 0 in RUN.

Optional Feature:
- Macro: RISCV_FPU_ARB_PERF_EN.
- When defined:
  - adds output perf_grant_cnt_o (NUM_REQ x 32): per-requester count of issued ops;
  - adds output perf_stall_cnt_o (32): cycles where some requester was valid but nothing issued;
  - both counters saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined: these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Add to riscv_fpu_types_pkg:
  - fpu_arb_state_e {ARB_RUN, ARB_DRAIN};
  - localparam FPU_ARB_MAX_REQ = 8;
  - typedef fpu_tag_t (logic [2:0]) for the requester index.
- One natural sub-module: riscv_fpu_tag_fifo, a parameterised synchronous FIFO with push, pop, full, empty and count, supporting push-and-pop when full.

Test Plan:
- **Single issue/return**: NUM_REQ=2; req_i[1] valid with FPU_ADD and rd_addr=5; fpu_ready_i=1. Expect fpu_req_o.rd_addr=5 in the same cycle and req_ready_o=2'b10. Return fpu_rsp_i.valid with data=32'h4040_0000 3 cycles later. Expect rsp_o[1].valid=1 carrying that data and rsp_o[0].valid=0.
- **Round-robin fairness**: both requesters valid continuously; fpu_ready_i=1; FPU returns each op 2 cycles later. Expect grants 0,1,0,1,... and responses routed in the same order.
- **Full FIFO**: MAX_OUTSTANDING=4; 4 issues with no responses. Expect req_ready_o=0 while count=4. In the next cycle drive a response together with a new valid request: expect a pop to the first issuer, the new op issued, and count staying at 4.
- **Backpressure**: fpu_ready_i=0 for 5 cycles with requester 0 valid. Expect no push, req_ready_o[0]=0 and the pointer held. Then fpu_ready_i=1: expect a single issue.
- **Flush**: 2 ops outstanding, then assert flush_i. Expect no grants despite valid requests. flush_done_o rises in the cycle after the 2nd response. Deassert flush_i: expect return to RUN and resumed grants.
- **Spurious/reset**: assert rst_i mid-flight with 3 ops outstanding; release it; then drive fpu_rsp_i.valid. Expect all rsp_o[k].valid=0 and spurious_rsp_o=1 sticky.
